// File: rtl/instr_pkg.sv
// Shared types and constants for the instruction loader/sequencer and its memory.
package instr_pkg;

  typedef enum logic [2:0] {IDLE, FETCH, CHECK, ISSUE, DRAIN, DONE} state_t;

  localparam int BUS_W             = 32;
  localparam int DEF_INSTR_NUM_BIT = 8;

  // Default command register address: all-ones of the INSTR_NUM_BIT+1 wide bus address
  localparam logic [DEF_INSTR_NUM_BIT:0] CMD_ADDR = '1;
  localparam logic [7:0] END_OPCODE    = 8'hFF;
  localparam int         CMD_START_BIT = 0;

  localparam int OPC_MSB = 63;
  localparam int OPC_LSB = 56;

  function automatic logic is_end(input logic [63:0] instr, input logic [7:0] end_opc);
    return instr[OPC_MSB:OPC_LSB] == end_opc;
  endfunction

endpackage

// File: rtl/instr_mem_1r1w.sv
// Depth x W instruction store, one write port and one registered read port.
// Kept as a plain array so it can be replaced by an SRAM macro.
module instr_mem_1r1w #(
  parameter int DEPTH = 255,
  parameter int AW    = 8,
  parameter int W     = 64
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/instr_loader_seq.sv
// Assembles 32-bit bus writes into 64-bit instructions, then on a start command
// issues them in order over valid/ready and raises an irq once the datapath drains.
module instr_loader_seq
  import instr_pkg::*;
#(
  parameter int         INSTR_NUM_BIT = DEF_INSTR_NUM_BIT,
  parameter int         INSTR_W       = 2 * BUS_W,
  parameter logic [7:0] END_OPCODE    = instr_pkg::END_OPCODE
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     CPU_instruction_valid,
  input  logic [INSTR_NUM_BIT:0]   CPU_instruction_addr,
  input  logic [BUS_W-1:0]         CPU_instruction_data,
  output logic                     CPU_instruction_irq,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic [INSTR_W-1:0]       instr_data,
  output logic [INSTR_NUM_BIT-1:0] instr_pc,
  input  logic                     exec_idle
);

  localparam int AW    = INSTR_NUM_BIT + 1;
  localparam int DEPTH = (2 ** INSTR_NUM_BIT) - 1;

  localparam logic [AW-1:0]            CMD_A   = '1;
  localparam logic [AW-1:0]            HOLE_A  = {{(AW-1){1'b1}}, 1'b0};
  localparam logic [INSTR_NUM_BIT-1:0] LAST_PC = {{(INSTR_NUM_BIT-1){1'b1}}, 1'b0};
  localparam logic [INSTR_NUM_BIT-1:0] PC_ONE  = {{(INSTR_NUM_BIT-1){1'b0}}, 1'b1};

  state_t                   state, next_state;
  logic [INSTR_NUM_BIT-1:0] pc, rd_addr, wr_slot;
  logic [BUS_W-1:0]         lo_hold;
  logic [INSTR_W-1:0]       rd_data;
  logic                     accept_wr, cmd_wr, start, lo_wr, hi_wr, handshake, rd_is_end;

  // Bus writes only land while the sequencer is parked, so the fetched slot never changes under it
  assign accept_wr = CPU_instruction_valid && (state == IDLE || state == DONE);
  assign cmd_wr    = accept_wr && (CPU_instruction_addr == CMD_A);
  assign start     = cmd_wr && CPU_instruction_data[CMD_START_BIT];
  assign lo_wr     = accept_wr && !CPU_instruction_addr[0] && (CPU_instruction_addr != HOLE_A);
  assign hi_wr     = accept_wr && CPU_instruction_addr[0] && (CPU_instruction_addr != CMD_A);
  assign wr_slot   = CPU_instruction_addr[AW-1:1];
  assign handshake = (state == ISSUE) && instr_ready;
  assign rd_is_end = is_end(rd_data, END_OPCODE);

  instr_mem_1r1w #(
    .DEPTH (DEPTH),
    .AW    (INSTR_NUM_BIT),
    .W     (INSTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (hi_wr),
    .waddr (wr_slot),
    .wdata ({CPU_instruction_data, lo_hold}),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // A command write in DONE always acknowledges the irq; without the start bit it parks in IDLE
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (start) next_state = FETCH;
      FETCH:   next_state = CHECK;
      CHECK:   next_state = rd_is_end ? DRAIN : ISSUE;
      ISSUE:   if (instr_ready) next_state = (pc == LAST_PC) ? DRAIN : FETCH;
      DRAIN:   if (exec_idle) next_state = DONE;
      DONE: begin
        if (start)       next_state = FETCH;
        else if (cmd_wr) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    instr_valid         = (state == ISSUE);
    CPU_instruction_irq = (state == DONE);
    rd_addr             = pc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= '0;
      lo_hold    <= '0;
      instr_data <= '0;
      instr_pc   <= '0;
    end else begin
      if (lo_wr) lo_hold <= CPU_instruction_data;
      if (start)
        pc <= '0;
      else if (handshake && pc != LAST_PC)
        pc <= pc + PC_ONE;
      if (state == CHECK && !rd_is_end) begin
        instr_data <= rd_data;
        instr_pc   <= pc;
      end
    end
  end

endmodule

// File: tb/tb_instr_loader_seq.sv
// Scoreboard bench for instr_loader_seq: directed programs, issue stream checked by a monitor.
module tb_instr_loader_seq;
  import instr_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        CPU_instruction_valid;
  logic [8:0]  CPU_instruction_addr;
  logic [31:0] CPU_instruction_data;
  logic        CPU_instruction_irq;
  logic        instr_valid;
  logic        instr_ready;
  logic [63:0] instr_data;
  logic [7:0]  instr_pc;
  logic        exec_idle;

  typedef struct packed {
    logic [7:0]  pc;
    logic [63:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  localparam logic [63:0] SLOT0 = 64'h0000_0001_0000_0002;
  localparam logic [63:0] SLOT1 = 64'h0100_0000_0000_0003;
  localparam logic [63:0] SLOT2 = 64'hFF00_0000_0000_0000;

  instr_loader_seq dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .CPU_instruction_valid (CPU_instruction_valid),
    .CPU_instruction_addr  (CPU_instruction_addr),
    .CPU_instruction_data  (CPU_instruction_data),
    .CPU_instruction_irq   (CPU_instruction_irq),
    .instr_valid           (instr_valid),
    .instr_ready           (instr_ready),
    .instr_data            (instr_data),
    .instr_pc              (instr_pc),
    .exec_idle             (exec_idle)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp)
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else
      n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // One bus write strobe; called and returns 2 time units after a rising edge
  task automatic applyStimulus(input logic [8:0] addr, input logic [31:0] data);
    CPU_instruction_valid = 1'b1;
    CPU_instruction_addr  = addr;
    CPU_instruction_data  = data;
    step();
    CPU_instruction_valid = 1'b0;
  endtask

  task automatic write_slot(input int slot, input logic [63:0] val);
    applyStimulus({slot[7:0], 1'b0}, val[31:0]);
    applyStimulus({slot[7:0], 1'b1}, val[63:32]);
  endtask

  function automatic logic [63:0] full_val(input int i);
    return {i[7:0], 8'h5A, 16'(i * 7), 32'h1000_0000 + 32'(i)};
  endfunction

  task automatic push_exp(input int pc, input logic [63:0] data);
    exp_t e;
    e.pc   = pc[7:0];
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic push_small_prog();
    push_exp(0, SLOT0);
    push_exp(1, SLOT1);
  endtask

  task automatic push_full_prog();
    for (int i = 0; i < 255; i++) push_exp(i, full_val(i));
  endtask

  task automatic wait_irq(input int limit, input string name);
    int n = 0;
    while (CPU_instruction_irq !== 1'b1 && n < limit) begin
      step();
      n++;
    end
    checkOutput(name, {63'd0, CPU_instruction_irq}, 64'd1);
  endtask

  task automatic wait_valid(input int limit, input string name);
    int n = 0;
    while (instr_valid !== 1'b1 && n < limit) begin
      step();
      n++;
    end
    checkOutput(name, {63'd0, instr_valid}, 64'd1);
  endtask

  task automatic wait_sb_empty(input int limit, input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      step();
      n++;
    end
    checkOutput(name, 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: every accepted instruction must match the head of the expected queue
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && instr_valid === 1'b1 && instr_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("[TB] FAIL issue_unexpected: got pc %0d data %h expected no issue at %0t",
                 instr_pc, instr_data, $time);
      end else begin
        e = exp_q.pop_front();
        checkOutput("issue_pc", {56'd0, instr_pc}, {56'd0, e.pc});
        checkOutput("issue_data", instr_data, e.data);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n                 = 1'b0;
    CPU_instruction_valid = 1'b0;
    CPU_instruction_addr  = '0;
    CPU_instruction_data  = '0;
    instr_ready           = 1'b1;
    exec_idle             = 1'b1;
    step();
    step();
    checkOutput("rst_valid", {63'd0, instr_valid}, 64'd0);
    checkOutput("rst_irq", {63'd0, CPU_instruction_irq}, 64'd0);
    checkOutput("rst_pc", {56'd0, instr_pc}, 64'd0);
    checkOutput("rst_data", instr_data, 64'd0);
    rst_n = 1'b1;
    step();

    $display("[TB] basic program");
    write_slot(0, SLOT0);
    write_slot(1, SLOT1);
    write_slot(2, SLOT2);
    push_small_prog();
    applyStimulus(CMD_ADDR, 32'd1);
    step();
    checkOutput("lat_cycle1", {63'd0, instr_valid}, 64'd0);
    step();
    checkOutput("lat_cycle2", {63'd0, instr_valid}, 64'd1);
    wait_irq(30, "basic_irq");
    checkOutput("basic_sb_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] clear without start");
    applyStimulus(CMD_ADDR, 32'd0);
    checkOutput("clear0_irq", {63'd0, CPU_instruction_irq}, 64'd0);
    repeat (4) step();
    checkOutput("clear0_norun", {63'd0, instr_valid}, 64'd0);

    $display("[TB] stall");
    instr_ready = 1'b0;
    push_small_prog();
    applyStimulus(CMD_ADDR, 32'd1);
    wait_valid(10, "stall_valid");
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall_hold_valid", {63'd0, instr_valid}, 64'd1);
      checkOutput("stall_hold_pc", {56'd0, instr_pc}, 64'd0);
      checkOutput("stall_hold_data", instr_data, SLOT0);
      step();
    end
    instr_ready = 1'b1;
    wait_irq(30, "stall_irq");
    checkOutput("stall_sb_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] drain");
    exec_idle = 1'b0;
    push_small_prog();
    applyStimulus(CMD_ADDR, 32'd1);
    checkOutput("restart_irq_clear", {63'd0, CPU_instruction_irq}, 64'd0);
    wait_sb_empty(30, "drain_issues");
    repeat (3) step();
    for (int i = 0; i < 10; i++) begin
      checkOutput("drain_irq_low", {63'd0, CPU_instruction_irq}, 64'd0);
      step();
    end
    exec_idle = 1'b1;
    checkOutput("drain_irq_before", {63'd0, CPU_instruction_irq}, 64'd0);
    step();
    checkOutput("drain_irq_rise", {63'd0, CPU_instruction_irq}, 64'd1);

    $display("[TB] busy write drop");
    instr_ready = 1'b0;
    push_small_prog();
    applyStimulus(CMD_ADDR, 32'd1);
    wait_valid(10, "busy_valid");
    write_slot(0, 64'hDEAD_BEEF_CAFE_F00D);
    instr_ready = 1'b1;
    wait_irq(30, "busy_irq");
    push_small_prog();
    applyStimulus(CMD_ADDR, 32'd1);
    wait_irq(30, "busy_rerun_irq");
    checkOutput("busy_sb_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] full memory");
    for (int i = 0; i < 255; i++) begin
      logic [63:0] v;
      v = full_val(i);
      applyStimulus({i[7:0], 1'b0}, v[31:0]);
      if (i == 7) applyStimulus(9'h1FE, 32'hFFFF_FFFF);
      applyStimulus({i[7:0], 1'b1}, v[63:32]);
    end
    push_full_prog();
    applyStimulus(CMD_ADDR, 32'd1);
    wait_irq(1200, "full_irq");
    checkOutput("full_sb_empty", 64'(exp_q.size()), 64'd0);
    checkOutput("full_last_pc", {56'd0, instr_pc}, 64'd254);

    $display("[TB] reset during issue");
    instr_ready = 1'b0;
    push_exp(0, full_val(0));
    applyStimulus(CMD_ADDR, 32'd1);
    wait_valid(10, "rst_mid_valid");
    checkOutput("rst_mid_pre_data", instr_data, full_val(0));
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_valid0", {63'd0, instr_valid}, 64'd0);
    checkOutput("rst_mid_irq0", {63'd0, CPU_instruction_irq}, 64'd0);
    checkOutput("rst_mid_pc0", {56'd0, instr_pc}, 64'd0);
    exp_q.delete();
    step();
    step();
    rst_n = 1'b1;
    repeat (3) step();
    checkOutput("rst_idle_valid", {63'd0, instr_valid}, 64'd0);
    checkOutput("rst_idle_irq", {63'd0, CPU_instruction_irq}, 64'd0);
    instr_ready = 1'b1;
    push_full_prog();
    applyStimulus(CMD_ADDR, 32'd1);
    wait_irq(1200, "retain_irq");
    checkOutput("retain_sb_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
